exp_bias_pipe_m: RTL and testbench
==================================

Name: exp_bias_pipe_m

Overview:
- Parametrised, pipelined exponent unit for the FP multiplier.
- Computes exp_x + exp_y + norm_inc - BIAS for any exponent width, then classifies and saturates the result (overflow/underflow).
- Sits between operand unpacking and final packing, in place of the single-register exponent phase.
- Adds a valid/ready handshake with back-pressure; the earlier block had a bare load enable.

Parameters:
- W_Exp, 8, exponent field width (8 single, 11 double; any value 4..15 legal).
- BIAS, 2**(W_Exp-1)-1, exponent bias; localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream presents an operand pair.
- in_ready  out  1  block accepts the pair this cycle.
- exp_x  in  W_Exp  biased exponent of X.
- exp_y  in  W_Exp  biased exponent of Y.
- norm_inc  in  1  +1 adjust from mantissa normalisation.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- exp_pr  out  W_Exp  saturated biased result exponent.
- ovf  out  1  result overflowed (exp_pr forced all-ones).
- unf  out  1  result underflowed (exp_pr forced zero).

Behaviour:
- Transfer occurs when valid && ready on the same rising edge; an input is consumed only on in_valid && in_ready.
- Stage 1 (S1): registers sum1 = exp_x + exp_y + norm_inc, W_Exp+1 bits unsigned; cannot overflow.
- Stage 2 (S2): computes and registers s = sum1 - BIAS as a W_Exp+2 bit two's-complement value.
  - s >= 2**W_Exp - 1: ovf=1, unf=0, exp_pr = all ones.
  - s <= 0: unf=1, ovf=0, exp_pr = 0.
  - Otherwise: exp_pr = s[W_Exp-1:0], flags 0.
- Each stage holds a valid bit (v1, v2).
  - S2 advances when !v2 || out_ready.
  - S1 advances when !v1 || S2 advances.
  - in_ready = !v1 || S2 advances. This is combinational from out_ready; no other comb path from inputs to outputs.
- Latency: 2 cycles from accepted input to out_valid.
- Throughput: 1 result per cycle when out_ready is held high.
- Stalled stages hold data and flags stable. out_valid never drops without a transfer.
- Results leave in strict acceptance order; no reordering, no drops.
- Simultaneous accept and emit in the same cycle is legal and sustains full rate.
- Reset:
  - v1 = v2 = 0, out_valid = 0, exp_pr = 0, ovf = 0, unf = 0, in_ready = 1 the cycle after reset.
  - Reset mid-operation discards all in-flight data.
  - Inputs are ignored while rst = 1.
- exp_pr, ovf and unf may be X-free garbage only when out_valid = 0. The design still registers zeros on reset.

Decomposition:
- Package fpu_mult_pkg:
  - function exp_bias(W), returns 2**(W-1)-1.
  - typedef for the flag pair {ovf, unf}.
  - constants SP_W_EXP=8 and DP_W_EXP=11.
- One natural sub-module: pipe_stage_m, parametrised W.
  - Ports: valid/ready in, valid/ready out, data register, synchronous active-high reset.
  - Instantiated twice, once per stage. The arithmetic sits outside it.

Test Plan:
- W_Exp=8, exp_x=127, exp_y=127, norm_inc=0 -> exp_pr=127 two cycles after acceptance, ovf=0, unf=0. With norm_inc=1 -> exp_pr=128.
- W_Exp=8 boundaries:
  - x=254, y=127 -> exp_pr=254, ovf=0.
  - x=255, y=127 -> exp_pr=255, ovf=1.
  - x=200, y=200 (s=273) -> exp_pr=255, ovf=1.
- W_Exp=8 underflow:
  - x=64, y=63 (s=0) -> exp_pr=0, unf=1.
  - x=10, y=10 (s=-107) -> exp_pr=0, unf=1.
  - x=64, y=64 (s=1) -> exp_pr=1, unf=0.
- Back-pressure: stream 4 pairs with out_ready=0 for 5 cycles.
  - in_ready falls after 2 accepts; exp_pr stays stable.
  - On release, all 4 results emerge in order with no loss or duplication.
  - Then 1 result/cycle under continuous valid.
- Reset mid-operation: assert rst with v1=v2=1 -> next cycle out_valid=0, exp_pr=0, in_ready=1. The first post-reset input returns only its own result.
- W_Exp=11: x=1023, y=1023 -> 1023; x=2046, y=1023 -> 2046; x=2047, y=1023 -> 2047 with ovf=1; x=500, y=523 -> 0 with unf=1.

Source files
------------

// File: rtl/fpu_mult_pkg.sv
// Shared types and constants for the FP multiplier datapath.
package fpu_mult_pkg;

    localparam int unsigned SP_W_EXP = 8;
    localparam int unsigned DP_W_EXP = 11;

    // Exception flags carried alongside the result exponent.
    typedef struct packed {
        logic ovf;
        logic unf;
    } exp_flags_t;

    // IEEE-style exponent bias for a w-bit exponent field.
    function automatic int unsigned exp_bias(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/exp_bias_pipe_m_stage.sv
// One elastic pipeline register with a valid/ready handshake.
module pipe_stage_m #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         advance;

    // Stage may load when empty or when its current content is leaving.
    always_comb begin
        advance = !valid_q || out_ready;
    end

    assign in_ready  = advance;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Hold data while stalled; capture new data only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (advance) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/exp_bias_pipe_m.sv
// Two-stage exponent unit: sum the biased exponents, then remove the bias
// and saturate to the representable range with overflow/underflow flags.
module exp_bias_pipe_m
    import fpu_mult_pkg::*;
#(
    parameter int unsigned W_Exp = SP_W_EXP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_Exp-1:0] exp_x,
    input  logic [W_Exp-1:0] exp_y,
    input  logic             norm_inc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_Exp-1:0] exp_pr,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned BIAS = exp_bias(W_Exp);
    localparam logic signed [W_Exp+1:0] BIAS_S  = $signed((W_Exp+2)'(BIAS));
    localparam logic signed [W_Exp+1:0] OVF_LIM = $signed((W_Exp+2)'((32'd1 << W_Exp) - 32'd1));
    localparam logic signed [W_Exp+1:0] ZERO_S  = '0;

    logic [W_Exp:0]          sum1_d;
    logic [W_Exp:0]          sum1_q;
    logic                    v1;
    logic                    s2_ready;
    logic signed [W_Exp+1:0] s;
    exp_flags_t              flags_d;
    exp_flags_t              flags_q;
    logic [W_Exp-1:0]        exp_d;
    logic [W_Exp+1:0]        s2_q;

    // Stage 1 operand: widened sum, which cannot overflow W_Exp+1 bits.
    always_comb begin
        sum1_d = {1'b0, exp_x} + {1'b0, exp_y} + (W_Exp+1)'(norm_inc);
    end

    pipe_stage_m #(.W(W_Exp + 1)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (sum1_d),
        .out_valid (v1),
        .out_ready (s2_ready),
        .out_data  (sum1_q)
    );

    // Remove the bias in signed arithmetic and clamp to [0, all-ones].
    always_comb begin
        s       = $signed({1'b0, sum1_q}) - BIAS_S;
        flags_d = '0;
        exp_d   = s[W_Exp-1:0];
        if (s >= OVF_LIM) begin
            flags_d.ovf = 1'b1;
            exp_d       = '1;
        end else if (s <= ZERO_S) begin
            flags_d.unf = 1'b1;
            exp_d       = '0;
        end
    end

    pipe_stage_m #(.W(W_Exp + 2)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_ready  (s2_ready),
        .in_data   ({flags_d, exp_d}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign flags_q = exp_flags_t'(s2_q[W_Exp+1:W_Exp]);
    assign exp_pr  = s2_q[W_Exp-1:0];
    assign ovf     = flags_q.ovf;
    assign unf     = flags_q.unf;

endmodule

// File: tb/tb_exp_bias_pipe_m.sv
// Randomised and directed bench for exp_bias_pipe_m, checked against a
// queue-based behavioural model of the exponent arithmetic.
module tb_exp_bias_pipe_m;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, out_ready = 1'b1, norm_inc = 1'b0;
    logic [7:0]  exp_x = '0, exp_y = '0;
    logic        in_ready, out_valid, ovf, unf;
    logic [7:0]  exp_pr;

    logic        in_valid11 = 1'b0, out_ready11 = 1'b1, norm_inc11 = 1'b0;
    logic [10:0] exp_x11 = '0, exp_y11 = '0;
    logic        in_ready11, out_valid11, ovf11, unf11;
    logic [10:0] exp_pr11;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_out    = 0;

    logic [17:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [9:0]  held;

    always #5 clk = ~clk;

    exp_bias_pipe_m #(.W_Exp(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exp_x(exp_x), .exp_y(exp_y), .norm_inc(norm_inc),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_pr(exp_pr), .ovf(ovf), .unf(unf)
    );

    exp_bias_pipe_m #(.W_Exp(11)) dut11 (
        .clk(clk), .rst(rst), .in_valid(in_valid11), .in_ready(in_ready11),
        .exp_x(exp_x11), .exp_y(exp_y11), .norm_inc(norm_inc11),
        .out_valid(out_valid11), .out_ready(out_ready11),
        .exp_pr(exp_pr11), .ovf(ovf11), .unf(unf11)
    );

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: true result = x + y + n - bias, clamped; packed {ovf, unf, exp[15:0]}.
    function automatic logic [17:0] model(input int x, input int y, input int n, input int w);
        int bias, top, s;
        bias = (1 << (w - 1)) - 1;
        top  = (1 << w) - 1;
        s    = x + y + n - bias;
        if (s >= top)   return {1'b1, 1'b0, 16'(top)};
        else if (s <= 0) return {1'b0, 1'b1, 16'd0};
        else             return {1'b0, 1'b0, 16'(s)};
    endfunction

    // Scoreboard: retire on output handshake, enqueue on input handshake,
    // and verify that a stalled output does not move.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {ovf, unf, exp_pr}, held);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("exp_pr", exp_pr, e[7:0]);
                    check("ovf", ovf, e[17]);
                    check("unf", unf, e[16]);
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {ovf, unf, exp_pr};
            if (in_valid && in_ready)
                exp_q.push_back(model(exp_x, exp_y, norm_inc, 8));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and hold it until accepted (bounded).
    task automatic push(input int x, input int y, input int n, input bit expect_ready);
        bit done = 1'b0;
        in_valid = 1'b1; exp_x = 8'(x); exp_y = 8'(y); norm_inc = n[0];
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (expect_ready) check("in_ready_full_rate", in_ready, 1);
            done = in_ready;
            step();
        end
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic t11(input int x, input int y, input int n);
        logic [17:0] e;
        e = model(x, y, n, 11);
        in_valid11 = 1'b1; exp_x11 = 11'(x); exp_y11 = 11'(y); norm_inc11 = n[0];
        check("w11_in_ready", in_ready11, 1);
        step();
        in_valid11 = 1'b0;
        check("w11_not_early", out_valid11, 0);
        step();
        check("w11_valid", out_valid11, 1);
        check("w11_exp_pr", exp_pr11, e[10:0]);
        check("w11_ovf", ovf11, e[17]);
        check("w11_unf", unf11, e[16]);
        step();
    endtask

    int vx[9] = '{127, 127, 254, 255, 200, 64, 10, 64, 1};
    int vy[9] = '{127, 127, 127, 127, 200, 63, 10, 64, 1};
    int vn[9] = '{0,   1,   0,   0,   0,   0,  0,  0,  0};
    int bx[4] = '{130, 140, 250, 20};
    int by[4] = '{100, 110, 120, 30};

    initial begin
        int idx, base, r;
        bit acc;

        // Reset values.
        drain(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_exp_pr", exp_pr, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Latency: result visible two cycles after presentation, not one.
        in_valid = 1'b1; exp_x = 8'd127; exp_y = 8'd127; norm_inc = 1'b0;
        step();
        in_valid = 1'b0;
        check("lat_not_early", out_valid, 0);
        step();
        check("lat_valid", out_valid, 1);
        check("lat_exp_pr", exp_pr, 127);
        drain(2);

        // Directed vectors streamed back to back at full rate.
        base = n_out;
        for (int i = 0; i < 9; i++) push(vx[i], vy[i], vn[i], 1'b1);
        in_valid = 1'b0;
        drain(2);
        check("full_rate_results", n_out - base, 9);

        // Back-pressure: only two pairs fit while downstream is stalled.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; exp_x = 8'(bx[idx]); exp_y = 8'(by[idx]); norm_inc = 1'b1;
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        check("bp_accepts", idx, 2);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 2; i < 4; i++) push(bx[i], by[i], 1, 1'b0);
        in_valid = 1'b0;
        drain(4);
        check("bp_drained", exp_q.size(), 0);

        // Wide-exponent instance.
        t11(1023, 1023, 0);
        t11(2046, 1023, 0);
        t11(2047, 1023, 0);
        t11(500, 523, 0);

        // Random traffic with random back-pressure, biased toward edge values.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 3);
            exp_x    = (r == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            exp_y    = (r == 1) ? 8'($urandom_range(0, 70))    : 8'($urandom);
            norm_inc = 1'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain(4);
        check("rand_drained", exp_q.size(), 0);

        // Reset with both stages full discards everything in flight.
        out_ready = 1'b0;
        push(200, 100, 0, 1'b0);
        push(150, 150, 1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        step();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_exp_pr", exp_pr, 0);
        check("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        base = n_out;
        push(100, 50, 1, 1'b1);
        in_valid = 1'b0;
        drain(4);
        check("midrst_single_result", n_out - base, 1);
        check("midrst_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
